// File: rtl/imux4_sel_seq_if.sv
// imux4_sel_seq_if: request/park inputs and complementary select rails of the 4:1 mux sequencer
interface imux4_sel_seq_if;
    logic       Req;
    logic [1:0] ChSel;
    logic       Park;
    logic       Sel0;
    logic       Sel0B;
    logic       Sel1;
    logic       Sel1B;
    logic       Ack;
    logic       Busy;
    logic       Oe;
    modport master (output Req, ChSel, Park, input Sel0, Sel0B, Sel1, Sel1B, Ack, Busy, Oe);
    modport slave (input Req, ChSel, Park, output Sel0, Sel0B, Sel1, Sel1B, Ack, Busy, Oe);
endinterface

// File: rtl/imux4_sel_seq.sv
// imux4_sel_seq: break-before-make select sequencer for a 4:1 inverting tri-state mux
module imux4_sel_seq #(
    parameter int DEAD_CYC = 2
) (
    input  logic           CLK,
    input  logic           RST,
    imux4_sel_seq_if.slave bus,
    inout  wire            VDD,
    inout  wire            VSS
);
    typedef enum logic [1:0] {ST_OFF, ST_BREAK, ST_DRIVE} state_t;
    state_t     state_q, state_d;
    logic [1:0] cur_q, cur_d, nxt_q, nxt_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] rails_q, rails_d;
    logic       ack_q, ack_d, busy_q, busy_d, oe_q, oe_d;
    logic       unused_rails;
    assign unused_rails = VDD ^ VSS;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_OFF;
            cur_q   <= '0;
            nxt_q   <= '0;
            cnt_q   <= '0;
            rails_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            nxt_q   <= nxt_d;
            cnt_q   <= cnt_d;
            rails_q <= rails_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            oe_q    <= oe_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        nxt_d   = nxt_q;
        cnt_d   = cnt_q;
        if (bus.Park) begin
            state_d = ST_OFF;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_OFF: if (bus.Req) begin
                    state_d = ST_DRIVE;
                    cur_d   = bus.ChSel;
                end
                ST_DRIVE: if (bus.Req && bus.ChSel != cur_q) begin
                    state_d = ST_BREAK;
                    nxt_d   = bus.ChSel;
                    cnt_d   = 4'(DEAD_CYC);
                end
                ST_BREAK: begin
                    // requests are ignored here; the counter alone decides the exit
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d = ST_DRIVE;
                        cur_d   = nxt_q;
                        cnt_d   = '0;
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end
    end
    // outputs are precomputed from the next state so every rail flips on one edge
    always_comb begin
        rails_d = state_d == ST_DRIVE ? {cur_d[1], ~cur_d[1], cur_d[0], ~cur_d[0]} : 4'b0000;
        ack_d   = state_d == ST_DRIVE && (state_q != ST_DRIVE || bus.Req);
        busy_d  = state_d == ST_BREAK;
        oe_d    = state_d == ST_DRIVE;
    end
    assign bus.Sel1  = rails_q[3];
    assign bus.Sel1B = rails_q[2];
    assign bus.Sel0  = rails_q[1];
    assign bus.Sel0B = rails_q[0];
    assign bus.Ack   = ack_q;
    assign bus.Busy  = busy_q;
    assign bus.Oe    = oe_q;
endmodule

// File: doc/imux4_sel_seq.md
IMUX4_SEL_SEQ -- requirements
Module: imux4_sel_seq

Interface
REQ-001 Parameter DEAD_CYC, default 2, break-before-make dead time in CLK cycles, legal range 1..15.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 Req  input  1  channel-change request, sampled on CLK rising edge.
REQ-005 ChSel  input  2  requested channel index 0..3, sampled with Req.
REQ-006 Park  input  1  force mux output to high-Z (all selects low).
REQ-007 Sel0  output  1  select bit 0, true rail.
REQ-008 Sel0B  output  1  select bit 0, complement rail.
REQ-009 Sel1  output  1  select bit 1, true rail.
REQ-010 Sel1B  output  1  select bit 1, complement rail.
REQ-011 Ack  output  1  one-cycle pulse: new channel now driven.
REQ-012 Busy  output  1  high while a request is in progress (BREAK state).
REQ-013 Oe  output  1  high when select rails form a valid complementary code.
REQ-014 VDD  inout  1  power rail, no logic function.
REQ-015 VSS  inout  1  ground rail, no logic function.

Function
REQ-016 Block SHALL drive the complementary select rails of a downstream 4:1 inverting tri-state mux; valid code = Sel0B=~Sel0 and Sel1B=~Sel1, with {Sel1,Sel0}=channel index.
REQ-017 States SHALL be OFF (all four rails 0, mux high-Z), BREAK (all four rails 0, dead-time count), DRIVE (valid code for CurCh).
REQ-018 All rail outputs, Ack, Busy, Oe SHALL be registered and change on the same edge; no cycle SHALL show Sel0=Sel0B=1 or Sel1=Sel1B=1.
REQ-019 Oe SHALL equal 1 exactly in DRIVE; Busy SHALL equal 1 exactly in BREAK.
REQ-020 OFF + Req (Park=0) at edge n: CurCh<=ChSel, DRIVE with new code and Ack=1 from edge n+1 (no dead time needed).
REQ-021 DRIVE + Req with ChSel==CurCh at edge n: stay DRIVE, rails unchanged, Ack=1 for cycle after edge n.
REQ-022 DRIVE + Req with ChSel!=CurCh at edge n: latch ChSel as NxtCh, enter BREAK at n+1, rails 0 for exactly DEAD_CYC cycles (edges n+1..n+DEAD_CYC).
REQ-023 BREAK completion: at edge n+DEAD_CYC+1 SHALL enter DRIVE, CurCh<=NxtCh, new code driven and Ack=1 for that one cycle.
REQ-024 Dead-time counter SHALL be 4 bits, load DEAD_CYC on BREAK entry, decrement per cycle, exit at terminal count; no wrap.
REQ-025 Req while Busy=1 SHALL be ignored (not queued); NxtCh unchanged.
REQ-026 Ack SHALL be a single-cycle pulse; Req held high continuously in DRIVE with ChSel==CurCh SHALL re-Ack every cycle.
REQ-027 Park=1 SHALL have priority over Req: from any state, next edge enters OFF, rails 0, Ack=0; a BREAK in progress SHALL be aborted with no Ack.
REQ-028 Park deassertion SHALL leave state OFF until next Req; CurCh retained.
REQ-029 ChSel SHALL be ignored when Req=0.

Reset
REQ-030 RST=1 SHALL immediately (asynchronously) force OFF: Sel0=Sel0B=Sel1=Sel1B=0, Ack=0, Busy=0, Oe=0, CurCh=0, NxtCh=0, counter=0.
REQ-031 RST asserted mid-BREAK or mid-DRIVE SHALL abandon the operation with no Ack; first edge after RST release with Req=1 follows REQ-020.
REQ-032 Rails SHALL never show a partially valid code during reset assertion or release.

Verification
REQ-033 Reset, Req=1 ChSel=2 at edge 1 -> edge 2: Sel1=1 Sel1B=0 Sel0=0 Sel0B=1, Oe=1, Ack=1 one cycle.
REQ-034 DRIVE ch2, DEAD_CYC=2, Req ChSel=1 at edge 5 -> edges 6-7 all rails 0, Busy=1; edge 8 Sel0=1 Sel0B=0 Sel1=0 Sel1B=1, Ack=1.
REQ-035 DRIVE ch1, Req ChSel=1 -> rails unchanged, Busy=0, Ack=1 next cycle.
REQ-036 In BREAK, Req ChSel=3 -> ignored; completion drives original NxtCh; Park=1 in BREAK -> OFF next edge, no Ack.
REQ-037 DEAD_CYC=15, RST pulse mid-BREAK -> rails 0 at once, no Ack; assertion checker: never Sel0&Sel0B or Sel1&Sel1B across random Req/ChSel/Park/RST run.
